conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/conv_window_ctrl.sv | 117 +++++++++++
 tb/tb_conv_window_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// Streaming controller for a 3x3 convolution line buffer.
// Tracks pixel position and flags complete in-frame windows.
module conv_window_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          s_valid,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_ready,
    output logic                          lb_en,
    output logic [DATA_WIDTH-1:0]         lb_din,
    output logic                          win_valid,
    input  logic                          m_ready,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          last_px;
    logic          win_hit;
    logic          done_nx;

    assign s_ready = (state == STREAM) && (!win_valid || m_ready);
    assign lb_en   = s_valid && s_ready;
    assign lb_din  = s_data;
    assign accept  = lb_en;
    assign busy    = (state != IDLE);
    assign last_px = (row == ROW_MAX) && (col == COL_MAX);
    assign win_hit = (row >= RW'(2)) && (col >= CW'(2));

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = STREAM;
            end
            STREAM: begin
                if (accept && last_px) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!win_valid || m_ready) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= done_nx;
        end
    end

    // Position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // An accept both retires any pending window and loads the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (accept) begin
            win_valid <= win_hit;
            if (win_hit) begin
                win_row <= row - RW'(2);
                win_col <= col - CW'(2);
            end
        end else if (win_valid && m_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl: vector table,
// directed corner sequences and randomized frames vs a model.
module tb_conv_window_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, lb_en, win_valid, busy, frame_done;
    logic [DW-1:0] lb_din;
    logic [1:0]    win_row, win_col;

    logic          start2 = 1'b0;
    logic          s_valid2 = 1'b1;
    logic          m_ready2 = 1'b1;
    logic [DW-1:0] s_data2 = '0;
    logic          s_ready2, lb_en2, win_valid2, busy2, frame_done2;
    logic [DW-1:0] lb_din2;
    logic [1:0]    win_row2;
    logic [2:0]    win_col2;

    always #5 clk = ~clk;

    conv_window_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .lb_en(lb_en), .lb_din(lb_din), .win_valid(win_valid),
        .m_ready(m_ready), .win_row(win_row), .win_col(win_col),
        .busy(busy), .frame_done(frame_done)
    );

    conv_window_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .s_valid(s_valid2), .s_data(s_data2), .s_ready(s_ready2),
        .lb_en(lb_en2), .lb_din(lb_din2), .win_valid(win_valid2),
        .m_ready(m_ready2), .win_row(win_row2), .win_col(win_col2),
        .busy(busy2), .frame_done(frame_done2)
    );

    typedef struct {
        bit         st;
        bit         sv;
        bit         mr;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[20];

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 stream, 2 drain
    int ph_m = 0;
    int n_m = 0;
    int wr_m = 0;
    int wc_m = 0;
    bit wv_m = 0;
    bit fd_m = 0;

    logic [8:0]    obs;
    logic          last_lb;
    logic [DW-1:0] last_din;
    int hs = 0;
    int lbc = 0;
    int fdc = 0;
    int fr = 0;
    int fc = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit st, bit sv, bit mr, bit sr, bit lb,
                                bit wv, logic [1:0] wr, logic [1:0] wc,
                                bit bz, bit fd);
        vec_t v;
        v.st  = st;
        v.sv  = sv;
        v.mr  = mr;
        v.exp = {sr, lb, wv, wr, wc, bz, fd};
        return v;
    endfunction

    task automatic model_reset();
        ph_m = 0;
        n_m  = 0;
        wr_m = 0;
        wc_m = 0;
        wv_m = 0;
        fd_m = 0;
    endtask

    task automatic step(input bit st, input bit sv, input bit mr);
        bit sr, acc, fdn;
        int r, c;
        logic [8:0] e;
        start   = st;
        s_valid = sv;
        m_ready = mr;
        s_data  = DW'((n_m + 1) << 8);
        @(negedge clk);
        sr  = (ph_m == 1) && (!wv_m || mr);
        acc = sv && sr;
        fdn = (ph_m == 2) && (!wv_m || mr);
        e   = {sr, acc, wv_m, 2'(wr_m), 2'(wc_m), ph_m != 0, fd_m};
        obs = {s_ready, lb_en, win_valid, win_row, win_col, busy, frame_done};
        chk("outputs", 32'(obs), 32'(e));
        chk("lb_din", 32'(lb_din), 32'(s_data));
        last_lb  = lb_en;
        last_din = lb_din;
        if (win_valid && m_ready) begin
            if (hs == 0) begin
                fr = int'(win_row);
                fc = int'(win_col);
            end
            hs++;
        end
        if (lb_en) lbc++;
        if (frame_done) fdc++;
        if (acc) begin
            r = n_m / W;
            c = n_m % W;
            if (r >= 2 && c >= 2) begin
                wv_m = 1;
                wr_m = r - 2;
                wc_m = c - 2;
            end else begin
                wv_m = 0;
            end
            n_m++;
        end else if (wv_m && mr) begin
            wv_m = 0;
        end
        case (ph_m)
            0: if (st) begin ph_m = 1; n_m = 0; end
            1: if (acc && n_m == W * H) ph_m = 2;
            default: if (fdn) ph_m = 0;
        endcase
        fd_m = fdn;
        @(posedge clk);
        #1;
    endtask

    // mode 0 steady, 1 s_valid gaps, 2 random, 3 start mid-frame, 4 stall
    task automatic frame(input int mode);
        int stalls = 0;
        bit done = 0;
        bit chk12 = 0;
        int f0 = fdc;
        hs  = 0;
        lbc = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            bit st = (k == 0);
            bit sv = 1;
            bit mr = 1;
            case (mode)
                1: sv = k[0];
                2: begin
                    sv = ($urandom % 2) != 0;
                    mr = ($urandom % 3) != 0;
                    if (ph_m == 1) st = ($urandom % 8) == 0;
                end
                3: st = (k == 0) || (k == 6);
                4: if (wv_m && stalls < 3) begin mr = 0; stalls++; end
                default: ;
            endcase
            step(st, sv, mr);
            if (mode == 4 && stalls == 3 && mr && !chk12) begin
                chk12 = 1;
                chk("stall_release", {15'd0, last_lb, last_din},
                    {15'd0, 1'b1, 16'h0C00});
            end
            done = (fdc != f0);
        end
        chk("frame_done_seen", 32'(done), 1);
        chk("windows", hs, (H - 2) * (W - 2));
        chk("first_win", fr * 4 + fc, 0);
        chk("accepts", lbc, W * H);
        step(0, 1, 1);
        step(0, 1, 1);
        chk("done_once", fdc - f0, 1);
    endtask

    initial begin
        int cnt2, lb2;
        bit fd2;
        logic [2:0] cols[$];

        tbl[0] = mk(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0);
        for (int i = 1; i <= 11; i++)
            tbl[i] = mk(0, 1, 1, 1, 1, 0, 2'd0, 2'd0, 1, 0);
        tbl[12] = mk(0, 1, 1, 1, 1, 1, 2'd0, 2'd0, 1, 0);
        tbl[13] = mk(0, 1, 1, 1, 1, 1, 2'd0, 2'd1, 1, 0);
        tbl[14] = mk(0, 1, 1, 1, 1, 0, 2'd0, 2'd1, 1, 0);
        tbl[15] = mk(0, 1, 1, 1, 1, 0, 2'd0, 2'd1, 1, 0);
        tbl[16] = mk(0, 1, 1, 1, 1, 1, 2'd1, 2'd0, 1, 0);
        tbl[17] = mk(0, 1, 1, 0, 0, 1, 2'd1, 2'd1, 1, 0);
        tbl[18] = mk(0, 1, 1, 0, 0, 0, 2'd1, 2'd1, 0, 1);
        tbl[19] = mk(0, 1, 1, 0, 0, 0, 2'd1, 2'd1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_state", 32'({s_ready, lb_en, win_valid, win_row,
                                win_col, busy, frame_done}), 0);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].st, tbl[i].sv, tbl[i].mr);
            chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
        end

        frame(1);
        frame(4);
        frame(3);

        step(1, 1, 1);
        repeat (7) step(0, 1, 1);
        reset = 1'b0;
        #1;
        chk("async_reset", 32'({s_ready, lb_en, win_valid, win_row,
                                win_col, busy, frame_done}), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 1, 1);
        frame(0);

        for (int i = 0; i < 20; i++) frame(2);

        cnt2 = 0;
        lb2  = 0;
        fd2  = 0;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int k = 0; k < 60 && !fd2; k++) begin
            @(negedge clk);
            if (win_valid2) begin
                cnt2++;
                cols.push_back(win_col2);
                chk("w5_row", 32'(win_row2), 0);
            end
            if (lb_en2) lb2++;
            if (frame_done2) fd2 = 1;
        end
        chk("w5_done", 32'(fd2), 1);
        chk("w5_windows", cnt2, 3);
        chk("w5_accepts", lb2, 15);
        for (int i = 0; i < cols.size(); i++)
            chk($sformatf("w5_col%0d", i), 32'(cols[i]), i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
